riscv_cache: RTL and testbench
==============================

# riscv_cache

Direct-mapped, write-back, write-allocate cache between the Riscv151 core's dcache/icache request ports and the shared main-memory interface. One instance serves each core port, and the top-level derives the core's `stall` from `cpu_req_ready`. Each line is one 128-bit memory beat, so a refill is one read transaction and a writeback is one write transaction.

## Interface
- `LINES`, default 64: number of lines; power of two; index width is log2(LINES).
- `MEM_ADDR_BITS`, default 28: memory address width, in 16-byte beat units.
- `clk` input, 1 bit: clock; all state updates on the rising edge.
- `reset` input, 1 bit: asynchronous, active-high.
- `cpu_req_valid` input, 1 bit: core request present.
- `cpu_req_ready` output, 1 bit: cache can accept a request.
- `cpu_req_addr` input, 32 bits: byte address; bits [1:0] are ignored.
- `cpu_req_data` input, 32 bits: store data.
- `cpu_req_write` input, 4 bits: byte-write mask; 0 means read.
- `cpu_resp_valid` output, 1 bit: read data valid, one-cycle pulse.
- `cpu_resp_data` output, 32 bits: read data.
- `mem_req_valid` output, 1 bit, and `mem_req_ready` input, 1 bit: memory command handshake.
- `mem_req_rw` output, 1 bit: 1 means write.
- `mem_req_addr` output, MEM_ADDR_BITS: line address.
- `mem_req_data_valid` output, 1 bit, and `mem_req_data_ready` input, 1 bit: write-data handshake.
- `mem_req_data_bits` output, 128 bits: writeback line.
- `mem_req_data_mask` output, 16 bits: always 16'hFFFF.
- `mem_resp_valid` input, 1 bit: refill data valid.
- `mem_resp_data` input, 128 bits: refill line.

## Operation
- Address split: tag = addr[31:4+IDX], index = addr[4+IDX-1:4], word = addr[3:2]. IDX = log2(LINES).
- States and transitions:
  - IDLE: `cpu_req_ready`=1. Accepting a request (valid & ready) registers addr, data and mask, then goes to LOOKUP.
  - LOOKUP: compare the stored tag and check the valid bit.
    - Read hit: pulse `cpu_resp_valid` with the selected word, then go to IDLE.
    - Write hit: merge the enabled bytes into the word, set dirty, then go to IDLE.
    - Miss with a dirty victim: go to WRITEBACK.
    - Miss with a clean or invalid victim: go to REFILL_REQ.
  - WRITEBACK: assert `mem_req_valid` with rw=1, addr = {victim tag, index}. Independently assert `mem_req_data_valid` with the victim line.
    - Each signal drops once its own handshake completes; the two handshakes may complete in the same cycle or in either order.
    - Leave for REFILL_REQ only when both have completed.
  - REFILL_REQ: assert `mem_req_valid` with rw=0, addr = {tag, index}. Go to REFILL_WAIT on `mem_req_ready`.
  - REFILL_WAIT: on `mem_resp_valid`, write the line and tag and set valid=1, dirty=0. Then go to LOOKUP, which is now guaranteed to hit and completes the original request.
- Writes produce no `cpu_resp_valid`. The core sees completion when `cpu_req_ready` returns.
- `mem_resp_valid` outside REFILL_WAIT is ignored.
- Valid and dirty bits are flops cleared by reset. Tag and data arrays are not reset.

## Timing
- Reset values:
  - state = IDLE.
  - `cpu_req_ready` = 0 while reset is high, 1 from the first cycle after release.
  - `cpu_resp_valid`, `mem_req_valid`, `mem_req_data_valid` = 0.
  - `cpu_resp_data`, `mem_req_data_bits` = 0.
  - All valid/dirty bits = 0.
- Hit latency: request accepted at cycle N, `cpu_resp_valid` at N+1, ready again at N+2.
- Clean miss: LOOKUP at N+1, REFILL_REQ at N+2, then memory latency, then REFILL_WAIT, then LOOKUP, which responds one cycle after `mem_resp_valid`.
- Dirty miss: WRITEBACK adds at least one cycle before REFILL_REQ.
- Outputs are stable while valid=1 and ready=0 on either memory handshake.
- Reset mid-operation:
  - Abandons the transaction and invalidates all lines; no dirty data is written back.
  - Memory responses arriving after reset are ignored.
- `cpu_req_valid` while not ready has no effect.

## Structure
- Shared `const.vh` holds the state encodings, `LINE_BITS`=128, `MEM_DATA_MASK_BITS`=16 and `MEM_ADDR_BITS`.
- Sub-module `cache_array`:
  - Tag and data storage with synchronous read, indexed at accept or refill time.
  - Word write with byte enables, plus full-line write.
  - Replaceable by SRAM macros without touching the FSM.
- The FSM, valid/dirty flops and memory handshakes live in the top module.

## Test plan
- Cold read of 0x0000_1004: expect mem read at addr 0x0000100. Return line 128'h...DDDD_CCCC_BBBB_AAAA. Expect `cpu_resp_data` = 32'hBBBB_BBBB one cycle after `mem_resp_valid`. A repeat read hits in 1 cycle with no mem traffic.
- Write hit: write 32'h1234_5678 with mask 4'b0011 to 0x1004 holding 32'hBBBB_BBBB, then read 0x1004. Expect 32'hBBBB_5678.
- Dirty eviction: after the write above, read 0x1404 (same index, LINES=64). Expect:
  - a mem write to 0x0000100 with the modified line and mask 16'hFFFF;
  - then a mem read to 0x0000140;
  - the correct response.
- Handshake skew: during writeback, hold `mem_req_data_ready` low for 5 cycles after `mem_req_ready`. Expect `mem_req_valid` to drop after 1 cycle, data to stay stable, and no refill until the data handshake completes.
- Reset mid-refill: assert reset in REFILL_WAIT, then deliver `mem_resp_valid`. Expect no response, all lines invalid, and the next read of the same address misses.

Source files
------------

// File: rtl/riscv_cache_pkg.sv
// Shared constants, FSM state type and byte-merge helper for riscv_cache.
package riscv_cache_pkg;

  localparam int unsigned LINE_BITS             = 128;
  localparam int unsigned MEM_DATA_MASK_BITS    = 16;
  localparam int unsigned DEFAULT_MEM_ADDR_BITS = 28;
  localparam int unsigned WORD_BITS             = 32;

  typedef enum logic [2:0] {
    S_IDLE,
    S_LOOKUP,
    S_WRITEBACK,
    S_REFILL_REQ,
    S_REFILL_WAIT
  } state_t;

  // Replace the bytes of old_word selected by be with those of new_word.
  function automatic logic [WORD_BITS-1:0] merge_bytes(
    input logic [WORD_BITS-1:0] old_word,
    input logic [WORD_BITS-1:0] new_word,
    input logic [3:0]           be
  );
    logic [WORD_BITS-1:0] r;
    r = old_word;
    for (int unsigned b = 0; b < 4; b++) begin
      if (be[b]) r[b*8 +: 8] = new_word[b*8 +: 8];
    end
    return r;
  endfunction

endpackage

// File: rtl/riscv_cache_if.sv
// Core-request and main-memory bus seen by one riscv_cache instance.
// slave: the cache itself; master: the core plus memory side.
interface riscv_cache_if
  import riscv_cache_pkg::*;
#(
  parameter int unsigned MEM_ADDR_BITS = DEFAULT_MEM_ADDR_BITS
);

  logic                          cpu_req_valid;
  logic                          cpu_req_ready;
  logic [31:0]                   cpu_req_addr;
  logic [31:0]                   cpu_req_data;
  logic [3:0]                    cpu_req_write;
  logic                          cpu_resp_valid;
  logic [31:0]                   cpu_resp_data;

  logic                          mem_req_valid;
  logic                          mem_req_ready;
  logic                          mem_req_rw;
  logic [MEM_ADDR_BITS-1:0]      mem_req_addr;
  logic                          mem_req_data_valid;
  logic                          mem_req_data_ready;
  logic [LINE_BITS-1:0]          mem_req_data_bits;
  logic [MEM_DATA_MASK_BITS-1:0] mem_req_data_mask;
  logic                          mem_resp_valid;
  logic [LINE_BITS-1:0]          mem_resp_data;

  modport slave (
    input  cpu_req_valid, cpu_req_addr, cpu_req_data, cpu_req_write,
    input  mem_req_ready, mem_req_data_ready, mem_resp_valid, mem_resp_data,
    output cpu_req_ready, cpu_resp_valid, cpu_resp_data,
    output mem_req_valid, mem_req_rw, mem_req_addr,
    output mem_req_data_valid, mem_req_data_bits, mem_req_data_mask
  );

  modport master (
    output cpu_req_valid, cpu_req_addr, cpu_req_data, cpu_req_write,
    output mem_req_ready, mem_req_data_ready, mem_resp_valid, mem_resp_data,
    input  cpu_req_ready, cpu_resp_valid, cpu_resp_data,
    input  mem_req_valid, mem_req_rw, mem_req_addr,
    input  mem_req_data_valid, mem_req_data_bits, mem_req_data_mask
  );

endinterface

// File: rtl/riscv_cache_array.sv
// Tag and line storage with a registered read port, byte-enabled word
// write and full-line write. No reset, so it can be swapped for SRAM macros.
module riscv_cache_array
  import riscv_cache_pkg::*;
#(
  parameter int unsigned LINES    = 64,
  parameter int unsigned TAG_BITS = 22,
  localparam int unsigned IDX_BITS = $clog2(LINES)
) (
  input  logic                 clk,
  input  logic                 rd_en,
  input  logic [IDX_BITS-1:0]  rd_idx,
  output logic [TAG_BITS-1:0]  rd_tag,
  output logic [LINE_BITS-1:0] rd_line,
  input  logic [3:0]           word_be,
  input  logic [IDX_BITS-1:0]  word_idx,
  input  logic [1:0]           word_sel,
  input  logic [31:0]          word_data,
  input  logic                 line_we,
  input  logic [IDX_BITS-1:0]  line_idx,
  input  logic [TAG_BITS-1:0]  line_tag,
  input  logic [LINE_BITS-1:0] line_data
);

  logic [LINE_BITS-1:0] data_mem [LINES];
  logic [TAG_BITS-1:0]  tag_mem  [LINES];

  // Storage writes: full-line refill or byte-merged word store.
  always_ff @(posedge clk) begin
    if (line_we) begin
      data_mem[line_idx] <= line_data;
      tag_mem[line_idx]  <= line_tag;
    end else if (|word_be) begin
      data_mem[word_idx][{word_sel, 5'b0} +: 32] <=
        merge_bytes(data_mem[word_idx][{word_sel, 5'b0} +: 32], word_data, word_be);
    end
  end

  // Read port; a refill also loads the read register so the following
  // lookup sees the new line without a second read.
  always_ff @(posedge clk) begin
    if (line_we) begin
      rd_line <= line_data;
      rd_tag  <= line_tag;
    end else if (rd_en) begin
      rd_line <= data_mem[rd_idx];
      rd_tag  <= tag_mem[rd_idx];
    end
  end

endmodule

// File: rtl/riscv_cache.sv
// Direct-mapped, write-back, write-allocate cache, one 128-bit beat per line.
module riscv_cache
  import riscv_cache_pkg::*;
#(
  parameter int unsigned LINES         = 64,
  parameter int unsigned MEM_ADDR_BITS = DEFAULT_MEM_ADDR_BITS
) (
  input logic         clk,
  input logic         reset,
  riscv_cache_if.slave bus
);

  localparam int unsigned IDX_BITS = $clog2(LINES);
  localparam int unsigned TAG_BITS = 32 - 4 - IDX_BITS;

  state_t               state_q, state_d;
  logic [31:2]          addr_q;
  logic [31:0]          data_q;
  logic [3:0]           mask_q;
  logic [LINES-1:0]     valid_q, dirty_q;
  logic                 wb_cmd_done_q, wb_data_done_q;

  logic [IDX_BITS-1:0]  idx_q;
  logic [TAG_BITS-1:0]  tag_q;
  logic [1:0]           word_q;
  logic [TAG_BITS-1:0]  rd_tag;
  logic [LINE_BITS-1:0] rd_line;
  logic                 cpu_ready, accept, hit, is_write, refill;
  logic                 mem_valid, mem_rw, data_valid, resp_valid;
  logic [MEM_ADDR_BITS-1:0] mem_addr;
  logic [3:0]           word_be;
  logic [1:0]           unused_addr_lsb;

  assign idx_q    = addr_q[4+IDX_BITS-1:4];
  assign tag_q    = addr_q[31:4+IDX_BITS];
  assign word_q   = addr_q[3:2];
  assign is_write = |mask_q;
  assign hit      = valid_q[idx_q] && (rd_tag == tag_q);
  assign cpu_ready = (state_q == S_IDLE) && !reset;
  assign accept   = bus.cpu_req_valid && cpu_ready;
  assign refill   = (state_q == S_REFILL_WAIT) && bus.mem_resp_valid;
  assign unused_addr_lsb = bus.cpu_req_addr[1:0];

  riscv_cache_array #(
    .LINES    (LINES),
    .TAG_BITS (TAG_BITS)
  ) u_array (
    .clk       (clk),
    .rd_en     (accept),
    .rd_idx    (bus.cpu_req_addr[4+IDX_BITS-1:4]),
    .rd_tag    (rd_tag),
    .rd_line   (rd_line),
    .word_be   (word_be),
    .word_idx  (idx_q),
    .word_sel  (word_q),
    .word_data (data_q),
    .line_we   (refill),
    .line_idx  (idx_q),
    .line_tag  (tag_q),
    .line_data (bus.mem_resp_data)
  );

  // State register.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) state_q <= S_IDLE;
    else       state_q <= state_d;
  end

  // Next state and per-state bus drive.
  always_comb begin
    state_d    = state_q;
    mem_valid  = 1'b0;
    mem_rw     = 1'b0;
    mem_addr   = MEM_ADDR_BITS'(addr_q[31:4]);
    data_valid = 1'b0;
    resp_valid = 1'b0;
    word_be    = '0;
    case (state_q)
      S_IDLE: begin
        if (accept) state_d = S_LOOKUP;
      end
      S_LOOKUP: begin
        if (hit) begin
          if (is_write) word_be = mask_q;
          else          resp_valid = 1'b1;
          state_d = S_IDLE;
        end else if (valid_q[idx_q] && dirty_q[idx_q]) begin
          state_d = S_WRITEBACK;
        end else begin
          state_d = S_REFILL_REQ;
        end
      end
      S_WRITEBACK: begin
        // Command and data handshakes are tracked separately; each drops
        // after its own transfer and the refill waits for both.
        mem_valid  = !wb_cmd_done_q;
        mem_rw     = 1'b1;
        mem_addr   = MEM_ADDR_BITS'({rd_tag, idx_q});
        data_valid = !wb_data_done_q;
        if ((wb_cmd_done_q || bus.mem_req_ready) &&
            (wb_data_done_q || bus.mem_req_data_ready))
          state_d = S_REFILL_REQ;
      end
      S_REFILL_REQ: begin
        mem_valid = 1'b1;
        if (bus.mem_req_ready) state_d = S_REFILL_WAIT;
      end
      S_REFILL_WAIT: begin
        if (bus.mem_resp_valid) state_d = S_LOOKUP;
      end
      default: state_d = S_IDLE;
    endcase
  end

  // Writeback handshake completion flags, cleared outside WRITEBACK.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      wb_cmd_done_q  <= 1'b0;
      wb_data_done_q <= 1'b0;
    end else if (state_q != S_WRITEBACK) begin
      wb_cmd_done_q  <= 1'b0;
      wb_data_done_q <= 1'b0;
    end else begin
      if (bus.mem_req_ready)      wb_cmd_done_q  <= 1'b1;
      if (bus.mem_req_data_ready) wb_data_done_q <= 1'b1;
    end
  end

  // Line valid/dirty state.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      valid_q <= '0;
      dirty_q <= '0;
    end else if (refill) begin
      valid_q[idx_q] <= 1'b1;
      dirty_q[idx_q] <= 1'b0;
    end else if ((state_q == S_LOOKUP) && hit && is_write) begin
      dirty_q[idx_q] <= 1'b1;
    end
  end

  // Capture the accepted request.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      addr_q <= '0;
      data_q <= '0;
      mask_q <= '0;
    end else if (accept) begin
      addr_q <= bus.cpu_req_addr[31:2];
      data_q <= bus.cpu_req_data;
      mask_q <= bus.cpu_req_write;
    end
  end

  assign bus.cpu_req_ready      = cpu_ready;
  assign bus.cpu_resp_valid     = resp_valid;
  assign bus.cpu_resp_data      = resp_valid ? rd_line[{word_q, 5'b0} +: 32] : '0;
  assign bus.mem_req_valid      = mem_valid;
  assign bus.mem_req_rw         = mem_rw;
  assign bus.mem_req_addr       = mem_addr;
  assign bus.mem_req_data_valid = data_valid;
  assign bus.mem_req_data_bits  = data_valid ? rd_line : '0;
  assign bus.mem_req_data_mask  = '1;

endmodule

// File: tb/tb_riscv_cache.sv
// Self-checking bench for riscv_cache: directed scenarios plus random
// traffic against a flat-memory / direct-mapped residency reference model.
module tb_riscv_cache;

  logic clk = 1'b0;
  logic reset;
  always #5 clk = ~clk;

  riscv_cache_if #(.MEM_ADDR_BITS(28)) bus ();

  riscv_cache #(
    .LINES         (64),
    .MEM_ADDR_BITS (28)
  ) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  int n_checks = 0;
  int n_fail   = 0;

  task automatic check(input string tag, input logic [255:0] got, input logic [255:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  // Reference: what the core should observe, what memory holds, residency.
  logic [127:0] core_mem [logic [27:0]];
  logic [127:0] back_mem [logic [27:0]];
  bit           ref_valid [64];
  bit           ref_dirty [64];
  logic [21:0]  ref_tag   [64];

  task automatic ensure_line(input logic [27:0] la);
    logic [127:0] l;
    if (!back_mem.exists(la)) begin
      l = {$urandom, $urandom, $urandom, $urandom};
      back_mem[la] = l;
      core_mem[la] = l;
    end
  endtask

  task automatic model_reset();
    for (int i = 0; i < 64; i++) begin
      ref_valid[i] = 0;
      ref_dirty[i] = 0;
    end
    core_mem = back_mem;
  endtask

  task automatic access(input logic [31:0] addr, input logic [3:0] mask, input logic [31:0] wdata,
                        input int cmd_delay, input int data_delay, input int rd_delay, input int lat,
                        output logic [31:0] resp_out);
    logic [27:0] la, wb_la, rd_addr_seen, wb_addr_seen, p_a;
    logic [5:0] idx;
    logic [21:0] tg;
    logic [1:0] wsel;
    logic [127:0] wb_line, line, wb_data_seen, p_db;
    logic [15:0] wb_mask_seen;
    logic [31:0] resp_seen, exp_word;
    bit exp_hit, exp_wb, is_wr, done, pend, rd_early, rdy, drdy, p_v, p_rdy, p_dv, p_drdy, p_rw;
    int k, k_done, k_resp, k_mresp, k_rdv, k_wbv, n_resp, n_wbc, n_wbd, n_rd, wb_c, d_c, r_c, cd;
    la = addr[31:4]; idx = addr[9:4]; tg = addr[31:10]; wsel = addr[3:2];
    is_wr = (mask != 4'b0);
    ensure_line(la);
    exp_hit = ref_valid[idx] && (ref_tag[idx] == tg);
    exp_wb  = !exp_hit && ref_valid[idx] && ref_dirty[idx];
    wb_la   = {ref_tag[idx], idx};
    wb_line = exp_wb ? core_mem[wb_la] : '0;
    line = core_mem[la];
    exp_word = line[wsel*32 +: 32];
    done = 0; pend = 0; rd_early = 0; resp_seen = '0; rd_addr_seen = '0; wb_addr_seen = '0;
    wb_data_seen = '0; wb_mask_seen = '0;
    k_done = -1; k_resp = -1; k_mresp = -1; k_rdv = -1; k_wbv = -1;
    n_resp = 0; n_wbc = 0; n_wbd = 0; n_rd = 0; wb_c = 0; d_c = 0; r_c = 0; cd = 0;
    p_v = 0; p_rdy = 0; p_dv = 0; p_drdy = 0; p_rw = 0; p_a = '0; p_db = '0;

    @(negedge clk);
    check("accept_ready", bus.cpu_req_ready, 1);
    bus.cpu_req_valid = 1'b1; bus.cpu_req_addr = addr;
    bus.cpu_req_data = wdata; bus.cpu_req_write = mask;
    @(posedge clk);
    #1 bus.cpu_req_valid = 1'b0;

    k = 0;
    while (k < 300 && !done) begin
      @(negedge clk);
      if (k >= 1 && bus.cpu_req_ready) begin
        done = 1; k_done = k;
      end else begin
        if (bus.cpu_resp_valid) begin n_resp++; k_resp = k; resp_seen = bus.cpu_resp_data; end
        if (p_v && !p_rdy)
          check("cmd_hold", {bus.mem_req_valid, bus.mem_req_rw, bus.mem_req_addr}, {1'b1, p_rw, p_a});
        if (p_dv && !p_drdy)
          check("data_hold", {bus.mem_req_data_valid, bus.mem_req_data_bits}, {1'b1, p_db});
        // refill data for an earlier read command
        bus.mem_resp_valid = 1'b0;
        if (pend) begin
          if (cd == 0) begin
            ensure_line(rd_addr_seen);
            bus.mem_resp_valid = 1'b1; bus.mem_resp_data = back_mem[rd_addr_seen];
            k_mresp = k; pend = 0;
          end else cd--;
        end
        if (bus.mem_req_valid) begin
          if (bus.mem_req_rw) begin rdy = (wb_c >= cmd_delay); wb_c++; if (k_wbv < 0) k_wbv = k; end
          else begin rdy = (r_c >= rd_delay); r_c++; if (k_rdv < 0) k_rdv = k; end
        end else rdy = 0;
        if (bus.mem_req_data_valid) begin drdy = (d_c >= data_delay); d_c++; end else drdy = 0;
        bus.mem_req_ready = rdy; bus.mem_req_data_ready = drdy;
        if (bus.mem_req_valid && !bus.mem_req_rw && exp_wb && (n_wbc == 0 || n_wbd == 0)) rd_early = 1;
        if (bus.mem_req_valid && rdy) begin
          if (bus.mem_req_rw) begin n_wbc++; wb_addr_seen = bus.mem_req_addr; end
          else begin n_rd++; rd_addr_seen = bus.mem_req_addr; pend = 1; cd = lat; end
        end
        if (bus.mem_req_data_valid && drdy) begin
          n_wbd++; wb_data_seen = bus.mem_req_data_bits; wb_mask_seen = bus.mem_req_data_mask;
        end
        // requests while busy must be ignored
        bus.cpu_req_valid = 1'($urandom_range(0, 1));
        bus.cpu_req_addr = $urandom; bus.cpu_req_data = $urandom; bus.cpu_req_write = 4'($urandom);
        p_v = bus.mem_req_valid; p_rdy = rdy; p_rw = bus.mem_req_rw; p_a = bus.mem_req_addr;
        p_dv = bus.mem_req_data_valid; p_drdy = drdy; p_db = bus.mem_req_data_bits;
      end
      k++;
    end
    bus.cpu_req_valid = 1'b0; bus.mem_req_ready = 1'b0;
    bus.mem_req_data_ready = 1'b0; bus.mem_resp_valid = 1'b0;

    check("completion", done, 1);
    check("resp_count", n_resp, is_wr ? 0 : 1);
    if (!is_wr && n_resp == 1) check("resp_data", resp_seen, exp_word);
    check("refill_count", n_rd, exp_hit ? 0 : 1);
    if (n_rd == 1) check("refill_addr", rd_addr_seen, la);
    check("wb_cmd_count", n_wbc, exp_wb ? 1 : 0);
    check("wb_data_count", n_wbd, exp_wb ? 1 : 0);
    if (exp_wb) begin
      check("wb_addr", wb_addr_seen, wb_la);
      check("wb_data", wb_data_seen, wb_line);
      check("wb_mask", wb_mask_seen, 16'hFFFF);
      check("refill_before_wb_done", rd_early, 0);
      check("wb_start_cycle", k_wbv, 1);
    end
    if (exp_hit) begin
      if (!is_wr) check("hit_resp_cycle", k_resp, 0);
      check("hit_done_cycle", k_done, 1);
    end else begin
      if (!exp_wb) check("refill_req_cycle", k_rdv, 1);
      if (!is_wr) check("miss_resp_cycle", k_resp, k_mresp + 1);
      check("miss_done_cycle", k_done, k_mresp + 2);
    end

    if (exp_wb) back_mem[wb_la] = wb_data_seen;
    if (is_wr) begin
      line = core_mem[la];
      for (int b = 0; b < 4; b++)
        if (mask[b]) line[wsel*32 + b*8 +: 8] = wdata[b*8 +: 8];
      core_mem[la] = line;
    end
    ref_dirty[idx] = exp_hit ? (ref_dirty[idx] || is_wr) : is_wr;
    ref_valid[idx] = 1;
    ref_tag[idx]   = tg;
    resp_out = resp_seen;
  endtask

  task automatic reset_mid_refill(input logic [31:0] addr);
    int k;
    bit fired;
    ensure_line(addr[31:4]);
    @(negedge clk);
    check("rmr_accept_ready", bus.cpu_req_ready, 1);
    bus.cpu_req_valid = 1'b1; bus.cpu_req_addr = addr; bus.cpu_req_write = 4'b0;
    @(posedge clk);
    #1 bus.cpu_req_valid = 1'b0;
    k = 0; fired = 0;
    while (k < 50 && !fired) begin
      @(negedge clk);
      bus.mem_req_ready = bus.mem_req_valid;
      if (bus.mem_req_valid) begin
        fired = 1;
        check("rmr_refill_cmd", {bus.mem_req_rw, bus.mem_req_addr}, {1'b0, addr[31:4]});
      end
      k++;
    end
    check("rmr_refill_seen", fired, 1);
    @(negedge clk);
    bus.mem_req_ready = 1'b0;
    reset = 1'b1;
    @(posedge clk); #1;
    check("rmr_rst_ready", bus.cpu_req_ready, 0);
    check("rmr_rst_memvalid", {bus.mem_req_valid, bus.mem_req_data_valid}, 2'b00);
    @(negedge clk);
    bus.mem_resp_valid = 1'b1; bus.mem_resp_data = {$urandom, $urandom, $urandom, $urandom};
    @(negedge clk);
    check("rmr_rst_resp", bus.cpu_resp_valid, 0);
    reset = 1'b0;
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      check("rmr_after_resp", bus.cpu_resp_valid, 0);
      check("rmr_after_ready", bus.cpu_req_ready, 1);
      check("rmr_after_mem", bus.mem_req_valid, 0);
    end
    bus.mem_resp_valid = 1'b0;
    model_reset();
  endtask

  task automatic idle_noise();
    @(negedge clk);
    bus.mem_resp_valid = 1'b1; bus.mem_resp_data = {$urandom, $urandom, $urandom, $urandom};
    @(negedge clk);
    bus.mem_resp_valid = 1'b0;
    check("idle_noise_resp", bus.cpu_resp_valid, 0);
    check("idle_noise_ready", bus.cpu_req_ready, 1);
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [31:0] r;
    logic [127:0] l;
    bus.cpu_req_valid = 0; bus.cpu_req_addr = '0; bus.cpu_req_data = '0; bus.cpu_req_write = '0;
    bus.mem_req_ready = 0; bus.mem_req_data_ready = 0; bus.mem_resp_valid = 0; bus.mem_resp_data = '0;
    reset = 1'b1;
    for (int i = 0; i < 64; i++) begin ref_valid[i] = 0; ref_dirty[i] = 0; ref_tag[i] = '0; end
    repeat (3) @(negedge clk);
    check("rst_ready", bus.cpu_req_ready, 0);
    check("rst_resp", {bus.cpu_resp_valid, bus.cpu_resp_data}, '0);
    check("rst_mem", {bus.mem_req_valid, bus.mem_req_data_valid, bus.mem_req_data_bits}, '0);
    reset = 1'b0;
    @(negedge clk);
    check("rst_release_ready", bus.cpu_req_ready, 1);

    // cold read, repeat hit, write hit, read-back
    l = {32'hDDDD_DDDD, 32'hCCCC_CCCC, 32'hBBBB_BBBB, 32'hAAAA_AAAA};
    back_mem[28'h0000100] = l;
    core_mem[28'h0000100] = l;
    access(32'h0000_1004, 4'b0, 32'h0, 0, 0, 2, 3, r);
    check("cold_read", r, 32'hBBBB_BBBB);
    access(32'h0000_1004, 4'b0, 32'h0, 0, 0, 0, 0, r);
    check("repeat_hit", r, 32'hBBBB_BBBB);
    access(32'h0000_1004, 4'b0011, 32'h1234_5678, 0, 0, 0, 0, r);
    access(32'h0000_1004, 4'b0, 32'h0, 0, 0, 0, 0, r);
    check("write_hit_read", r, 32'hBBBB_5678);

    // dirty eviction with command accepted first and data 5 cycles later
    access(32'h0000_1404, 4'b0, 32'h0, 0, 6, 1, 2, r);
    l = back_mem[28'h0000100];
    check("evicted_line", l, {32'hDDDD_DDDD, 32'hCCCC_CCCC, 32'hBBBB_5678, 32'hAAAA_AAAA});

    // data handshake first, then both in the same cycle
    access(32'h0000_1408, 4'b1111, 32'hCAFE_F00D, 0, 0, 0, 0, r);
    access(32'h0000_1804, 4'b0, 32'h0, 4, 0, 0, 1, r);
    access(32'h0000_1804, 4'b1000, 32'h5A00_0000, 0, 0, 0, 0, r);
    access(32'h0000_1C04, 4'b0, 32'h0, 2, 2, 0, 0, r);

    // reset during refill: dirty line at index 1 must be dropped
    access(32'h0000_1010, 4'b0101, 32'h1111_2222, 0, 0, 1, 1, r);
    reset_mid_refill(32'h0000_2008);
    access(32'h0000_2008, 4'b0, 32'h0, 0, 0, 0, 2, r);
    access(32'h0000_1010, 4'b0, 32'h0, 0, 0, 0, 0, r);

    // random traffic over a small footprint to mix hits, misses and evictions
    for (int n = 0; n < 150; n++) begin
      logic [31:0] a;
      logic [3:0] m;
      a = (32'($urandom_range(0, 3)) << 10) | (32'($urandom_range(0, 7)) << 4) |
          (32'($urandom_range(0, 3)) << 2) | 32'($urandom_range(0, 3));
      m = ($urandom_range(0, 1) == 0) ? 4'b0 : 4'($urandom_range(1, 15));
      access(a, m, $urandom, $urandom_range(0, 3), $urandom_range(0, 3),
             $urandom_range(0, 3), $urandom_range(0, 4), r);
      if ($urandom_range(0, 7) == 0) idle_noise();
    end

    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
    $finish;
  end

endmodule
